// File: rtl/reg_edgecount_trigger.sv
// Register-mapped edge-counting trigger qualifier on the shared 8-bit register bus.
// Optional glitch filter and FILT register are built when EDGETRIG_FILTER_EN is defined.
module reg_edgecount_trigger #(
   parameter logic [5:0]  ADDR_EDGETRIG = 6'd53,
   parameter int unsigned PULSE_LEN     = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [5:0]  reg_address,
   input  logic [15:0] reg_bytecnt,
   input  logic [7:0]  reg_datai,
   output logic [7:0]  reg_datao,
   input  logic [15:0] reg_size,
   input  logic        reg_read,
   input  logic        reg_write,
   input  logic        reg_addrvalid,
   input  logic [5:0]  reg_hypaddress,
   output logic [15:0] reg_hyplen,
   output logic        reg_stream,
   input  logic        trig_in,
   output logic        trig_out
);

   localparam logic [3:0] PULSE_LAST = 4'(PULSE_LEN - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_FIRE  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] target_q, target_d;
   logic [15:0] count_q, count_d;
   logic [3:0]  ctrl_q, ctrl_d;
   logic [3:0]  pcnt_q, pcnt_d;
   logic        fired_q, fired_d;
   logic        trig_out_q, trig_out_d;
   logic        sync1_q, sync2_q;
   logic        level_q, level_d;
   logic        edge_q, edge_d;
   logic [7:0]  filt_rd;
   logic [15:0] tgt_eff;
   logic        addr_hit, wr_hit, ctrl_wr;
   logic        unused_ok;

   assign unused_ok  = ^reg_size;
   assign addr_hit   = reg_addrvalid && (reg_address == ADDR_EDGETRIG);
   assign wr_hit     = reg_write && addr_hit;
   assign ctrl_wr    = wr_hit && (reg_bytecnt == 16'd2);
   assign tgt_eff    = (target_q == 16'd0) ? 16'd1 : target_q;
   assign reg_hyplen = (reg_hypaddress == ADDR_EDGETRIG) ? 16'd7 : 16'd0;
   assign reg_stream = 1'b0;
   assign trig_out   = trig_out_q;

`ifdef EDGETRIG_FILTER_EN
   logic [7:0] filt_q, filt_d;
   logic [7:0] fcnt_q, fcnt_d;

   // A new level is adopted once it has differed from the accepted level for FILT+1 cycles.
   always_comb begin
      filt_d  = filt_q;
      fcnt_d  = 8'd0;
      level_d = level_q;
      if (wr_hit && (reg_bytecnt == 16'd3)) filt_d = reg_datai;
      if (sync2_q != level_q) begin
         if (fcnt_q >= filt_q) level_d = sync2_q;
         else                  fcnt_d  = fcnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         filt_q <= 8'd0;
         fcnt_q <= 8'd0;
      end else begin
         filt_q <= filt_d;
         fcnt_q <= fcnt_d;
      end
   end

   assign filt_rd = filt_q;
`else
   always_comb level_d = sync2_q;
   assign filt_rd = 8'd0;
`endif

   // Direction is chosen from CTRL at detection time; the edge is counted one cycle later.
   always_comb begin
      edge_d = 1'b0;
      if (level_d != level_q)
         edge_d = ctrl_q[1] | (ctrl_q[0] ? level_d : ~level_d);
   end

   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      count_d  = count_q;
      ctrl_d   = ctrl_q;
      pcnt_d   = pcnt_q;
      fired_d  = fired_q;
      if (wr_hit && (reg_bytecnt == 16'd0)) target_d[7:0]  = reg_datai;
      if (wr_hit && (reg_bytecnt == 16'd1)) target_d[15:8] = reg_datai;
      if (ctrl_wr) begin
         // A CTRL write overrides whatever the sequencer would do, including a same-cycle edge.
         ctrl_d  = reg_datai[3:0];
         fired_d = 1'b0;
         pcnt_d  = 4'd0;
         if (reg_datai[3]) begin
            state_d = ST_ARMED;
            count_d = 16'd0;
         end else begin
            state_d = ST_IDLE;
         end
      end else begin
         case (state_q)
            ST_ARMED: begin
               if (count_q >= tgt_eff) begin
                  state_d = ST_FIRE;
                  pcnt_d  = 4'd0;
                  fired_d = 1'b1;
               end else if (edge_q && (count_q != 16'hFFFF)) begin
                  count_d = count_q + 16'd1;
               end
            end
            ST_FIRE: begin
               if (pcnt_q == PULSE_LAST) begin
                  if (ctrl_q[2]) begin
                     ctrl_d[3] = 1'b0;
                     state_d   = ST_IDLE;
                  end else begin
                     count_d = 16'd0;
                     state_d = ST_ARMED;
                  end
               end else begin
                  pcnt_d = pcnt_q + 4'd1;
               end
            end
            default: ;
         endcase
      end
      trig_out_d = (state_d == ST_FIRE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         level_q    <= 1'b0;
         edge_q     <= 1'b0;
         state_q    <= ST_IDLE;
         target_q   <= 16'd1;
         count_q    <= 16'd0;
         ctrl_q     <= 4'd0;
         pcnt_q     <= 4'd0;
         fired_q    <= 1'b0;
         trig_out_q <= 1'b0;
      end else begin
         sync1_q    <= trig_in;
         sync2_q    <= sync1_q;
         level_q    <= level_d;
         edge_q     <= edge_d;
         state_q    <= state_d;
         target_q   <= target_d;
         count_q    <= count_d;
         ctrl_q     <= ctrl_d;
         pcnt_q     <= pcnt_d;
         fired_q    <= fired_d;
         trig_out_q <= trig_out_d;
      end
   end

   always_comb begin
      reg_datao = 8'd0;
      if (reg_read && addr_hit) begin
         case (reg_bytecnt)
            16'd0:   reg_datao = target_q[7:0];
            16'd1:   reg_datao = target_q[15:8];
            16'd2:   reg_datao = {4'd0, ctrl_q};
            16'd3:   reg_datao = filt_rd;
            16'd4:   reg_datao = count_q[7:0];
            16'd5:   reg_datao = count_q[15:8];
            16'd6:   reg_datao = {6'd0, (state_q != ST_IDLE), fired_q};
            default: reg_datao = 8'd0;
         endcase
      end
   end

endmodule

// File: tb/tb_reg_edgecount_trigger.sv
// Self-checking bench for reg_edgecount_trigger: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the register/trigger rules.
module tb_reg_edgecount_trigger;

   localparam int         PLEN = 4;
   localparam logic [5:0] ADDR = 6'd53;
`ifdef EDGETRIG_FILTER_EN
   localparam bit FILT_EN  = 1'b1;
   localparam int FILT_LAT = 5;
`else
   localparam bit FILT_EN  = 1'b0;
   localparam int FILT_LAT = 0;
`endif

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [5:0]  reg_address = '0;
   logic [15:0] reg_bytecnt = '0;
   logic [7:0]  reg_datai = '0;
   logic [7:0]  reg_datao;
   logic [15:0] reg_size = '0;
   logic        reg_read = 1'b0;
   logic        reg_write = 1'b0;
   logic        reg_addrvalid = 1'b0;
   logic [5:0]  reg_hypaddress = '0;
   logic [15:0] reg_hyplen;
   logic        reg_stream;
   logic        trig_in = 1'b0;
   logic        trig_out;

   always #5 clk = ~clk;

   reg_edgecount_trigger #(.ADDR_EDGETRIG(ADDR), .PULSE_LEN(PLEN)) dut (
      .clk(clk), .reset_n(reset_n), .reg_address(reg_address), .reg_bytecnt(reg_bytecnt),
      .reg_datai(reg_datai), .reg_datao(reg_datao), .reg_size(reg_size), .reg_read(reg_read),
      .reg_write(reg_write), .reg_addrvalid(reg_addrvalid), .reg_hypaddress(reg_hypaddress),
      .reg_hyplen(reg_hyplen), .reg_stream(reg_stream), .trig_in(trig_in), .trig_out(trig_out)
   );

   int tests = 0, fails = 0, cyc = 0;
   // behavioural model: mode 0 idle, 1 armed, 2 firing with m_left cycles to go
   int m_target, m_ctrl, m_filt, m_count, m_mode, m_left, m_fired, m_stable;
   bit m_s1, m_s2, m_lvl, m_edge;
   // pulse monitor
   int n_pulses = 0, last_rise = 0, last_width = 0, cur_w = 0;
   bit prev_t = 1'b0;

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_target = 1; m_ctrl = 0; m_filt = 0; m_count = 0; m_mode = 0; m_left = 0;
      m_fired = 0; m_stable = 0; m_s1 = 0; m_s2 = 0; m_lvl = 0; m_edge = 0;
      prev_t = 1'b0; cur_w = 0;
   endtask

   task automatic model_step();
      bit wr, nl, old_edge;
      int bc, old_target, tgt;
      wr = reg_write && reg_addrvalid && (reg_address == ADDR);
      bc = int'(reg_bytecnt);
      old_target = m_target;
      old_edge = m_edge;
      // input qualification: synchronized level must hold FILT+1 cycles to be accepted
      nl = m_lvl;
      if (!FILT_EN) nl = m_s2;
      else if (m_s2 != m_lvl) begin
         if (m_stable >= m_filt) begin nl = m_s2; m_stable = 0; end
         else m_stable++;
      end else m_stable = 0;
      m_edge = (nl != m_lvl) && (((m_ctrl & 2) != 0) || (((m_ctrl & 1) != 0) ? nl : !nl));
      m_lvl = nl;
      m_s2 = m_s1;
      m_s1 = trig_in;
      if (wr && bc == 0) m_target = (m_target & 'hFF00) | int'(reg_datai);
      if (wr && bc == 1) m_target = (m_target & 'h00FF) | (int'(reg_datai) << 8);
      if (wr && bc == 3 && FILT_EN) m_filt = int'(reg_datai);
      if (wr && bc == 2) begin
         m_ctrl = int'(reg_datai) & 15;
         m_fired = 0;
         if (reg_datai[3]) begin m_mode = 1; m_count = 0; end
         else m_mode = 0;
      end else if (m_mode == 1) begin
         tgt = (old_target == 0) ? 1 : old_target;
         if (m_count >= tgt) begin m_mode = 2; m_left = PLEN; m_fired = 1; end
         else if (old_edge && m_count < 65535) m_count++;
      end else if (m_mode == 2) begin
         m_left--;
         if (m_left == 0) begin
            if ((m_ctrl & 4) != 0) begin m_ctrl = m_ctrl & 7; m_mode = 0; end
            else begin m_count = 0; m_mode = 1; end
         end
      end
   endtask

   function automatic int exp_datao();
      if (!(reg_read && reg_addrvalid && reg_address == ADDR)) return 0;
      case (int'(reg_bytecnt))
         0: return m_target & 255;
         1: return (m_target >> 8) & 255;
         2: return m_ctrl;
         3: return FILT_EN ? m_filt : 0;
         4: return m_count & 255;
         5: return (m_count >> 8) & 255;
         6: return ((m_mode != 0) ? 2 : 0) | m_fired;
         default: return 0;
      endcase
   endfunction

   task automatic compare();
      chk("trig_out", int'(trig_out), (m_mode == 2) ? 1 : 0);
      chk("reg_datao", int'(reg_datao), exp_datao());
      chk("reg_hyplen", int'(reg_hyplen), (reg_hypaddress == ADDR) ? 7 : 0);
      chk("reg_stream", int'(reg_stream), 0);
      if (trig_out && !prev_t) begin n_pulses++; last_rise = cyc; cur_w = 1; end
      else if (trig_out) cur_w++;
      if (!trig_out && prev_t) last_width = cur_w;
      prev_t = trig_out;
   endtask

   task automatic step();
      @(posedge clk);
      if (!reset_n) model_reset();
      else model_step();
      cyc++;
      #1;
      if (reset_n) compare();
   endtask

   task automatic wr(input int bc, input int d);
      reg_write = 1'b1; reg_addrvalid = 1'b1; reg_address = ADDR;
      reg_bytecnt = 16'(bc); reg_datai = 8'(d);
      step();
      reg_write = 1'b0;
   endtask

   task automatic rd_chk(input string nm, input int bc, input int exp);
      reg_read = 1'b1; reg_addrvalid = 1'b1; reg_address = ADDR; reg_bytecnt = 16'(bc);
      #1;
      chk(nm, int'(reg_datao), exp);
      reg_read = 1'b0;
      step();
   endtask

   initial begin
      int k, np0;
      bit seen;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      step();

      // reset state and hyper-length / unmatched address
      chk("rst_trig_out", int'(trig_out), 0);
      rd_chk("rst_target_lo", 0, 8'h01);
      rd_chk("rst_target_hi", 1, 8'h00);
      rd_chk("rst_ctrl", 2, 8'h00);
      rd_chk("rst_count_lo", 4, 8'h00);
      rd_chk("rst_status", 6, 8'h00);
      reg_hypaddress = ADDR; #1; chk("hyplen_hit", int'(reg_hyplen), 7);
      reg_hypaddress = 6'd12; #1; chk("hyplen_miss", int'(reg_hyplen), 0);
      reg_read = 1'b1; reg_addrvalid = 1'b1; reg_address = 6'd52; reg_bytecnt = 16'd0; #1;
      chk("read_unmatched", int'(reg_datao), 0);
      reg_read = 1'b0;
      step();

      // TARGET=3, rising oneshot: one pulse 4 cycles after the 3rd edge
      wr(0, 3); wr(1, 0); wr(3, 0); wr(2, 8'h0D);
      np0 = n_pulses; k = 0;
      for (int e = 0; e < 3; e++) begin
         trig_in = 1'b1; k = cyc + 1;
         repeat (10) step();
         trig_in = 1'b0;
         repeat (10) step();
      end
      chk("t1_pulses", n_pulses - np0, 1);
      chk("t1_latency", last_rise - k, 4);
      chk("t1_width", last_width, PLEN);
      rd_chk("t1_status", 6, 8'h01);
      rd_chk("t1_count", 4, 3);
      rd_chk("t1_ctrl", 2, 8'h05);

      // TARGET=2, both edges, repeating: 4 edges give 2 pulses
      wr(0, 2); wr(2, 8'h0A);
      np0 = n_pulses;
      for (int e = 0; e < 4; e++) begin
         trig_in = ~trig_in;
         repeat (15) step();
         if (e == 1) rd_chk("t2_count_after_p1", 4, 0);
      end
      chk("t2_pulses", n_pulses - np0, 2);
      rd_chk("t2_count_after_p2", 4, 0);

      // filter: glitch rejection and added latency
      wr(3, 5); wr(0, 1); wr(1, 0); wr(2, 8'h0D);
      rd_chk("t3_filt", 3, FILT_EN ? 5 : 0);
`ifdef EDGETRIG_FILTER_EN
      np0 = n_pulses;
      trig_in = 1'b1; repeat (3) step(); trig_in = 1'b0;
      repeat (20) step();
      chk("t3_glitch_ignored", n_pulses - np0, 0);
`endif
      np0 = n_pulses;
      trig_in = 1'b1; k = cyc + 1;
      repeat (10) step();
      trig_in = 1'b0;
      repeat (20) step();
      chk("t3_pulses", n_pulses - np0, 1);
      chk("t3_latency", last_rise - k, 4 + FILT_LAT);
      wr(3, 0);

      // TARGET lowered below COUNT fires next cycle; CTRL write drops a same-cycle edge
      wr(0, 100); wr(1, 0); wr(2, 8'h0B);
      for (int e = 0; e < 4; e++) begin trig_in = ~trig_in; repeat (8) step(); end
      rd_chk("t4_count4", 4, 4);
      wr(0, 2);
      chk("t4_not_yet", int'(trig_out), 0);
      step();
      chk("t4_fire_next", int'(trig_out), 1);
      repeat (10) step();
      trig_in = ~trig_in; repeat (8) step();
      rd_chk("t4_count1", 4, 1);
      trig_in = ~trig_in;
      repeat (3) step();
      wr(2, 8'h08);
      repeat (5) step();
      rd_chk("t4_edge_dropped", 4, 0);
      rd_chk("t4_ctrl", 2, 8'h08);

      // asynchronous reset in the middle of a pulse
      trig_in = 1'b0;
      wr(0, 1); wr(2, 8'h09);
      trig_in = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         step();
         seen = trig_out;
      end
      chk("t5_fire_seen", int'(seen), 1);
      #2 reset_n = 1'b0;
      model_reset();
      #1 chk("t5_trig_out_async", int'(trig_out), 0);
      rd_chk("t5_target_lo", 0, 8'h01);
      rd_chk("t5_target_hi", 1, 8'h00);
      rd_chk("t5_ctrl", 2, 8'h00);
      rd_chk("t5_count", 4, 8'h00);
      trig_in = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      step();

      // randomized traffic against the model
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 5) == 0) trig_in = ~trig_in;
         reg_addrvalid = ($urandom_range(0, 7) != 0);
         reg_address = ($urandom_range(0, 3) == 0) ? 6'($urandom) : ADDR;
         reg_bytecnt = 16'($urandom_range(0, 8));
         reg_write = ($urandom_range(0, 19) == 0);
         reg_read = ($urandom_range(0, 1) == 1);
         reg_hypaddress = ($urandom_range(0, 1) == 1) ? ADDR : 6'($urandom);
         case (int'(reg_bytecnt))
            0: reg_datai = 8'($urandom_range(0, 5));
            1: reg_datai = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'd0;
            2: reg_datai = 8'($urandom) | (($urandom_range(0, 3) != 0) ? 8'h08 : 8'h00);
            3: reg_datai = 8'($urandom_range(0, 3));
            default: reg_datai = 8'($urandom);
         endcase
         step();
      end
      reg_write = 1'b0; reg_read = 1'b0;
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
